// File: rtl/instr_encoder.sv
// Purpose : packs decoded RV32I fields into a 32-bit instruction word and queues {err, instr} in a DEPTH-entry FIFO.
// Latency : a request accepted at edge N is at the head (out_valid=1) after edge N; no input-to-output bypass.
// Backpres: req_ready = not full and no flush; a pop on a full queue does not free a slot in the same cycle.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset (clears pointers, count and storage)
//   flush              synchronous queue clear; same-cycle push/pop discarded, stored data kept
//   req_valid/ready    request handshake; req_kind selects the instruction class (9-15 illegal)
//   req_funct3, req_funct7b5, req_rd, req_rs1, req_rs2, req_imm   decoded instruction fields
//   out_valid/ready    head handshake; out_instr/out_err show the entry at the read pointer
//   count              occupied entries
//
// Optional feature: define ENC_RANGE_CHECK_EN to flag out-of-range / misaligned immediates as errors.
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [3:0]                 req_kind,
    input  logic [2:0]                 req_funct3,
    input  logic                       req_funct7b5,
    input  logic [4:0]                 req_rd,
    input  logic [4:0]                 req_rs1,
    input  logic [4:0]                 req_rs2,
    input  logic [31:0]                req_imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic                       out_err,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [3:0] K_LOAD   = 4'd0;
    localparam logic [3:0] K_OPIMM  = 4'd1;
    localparam logic [3:0] K_AUIPC  = 4'd2;
    localparam logic [3:0] K_STORE  = 4'd3;
    localparam logic [3:0] K_OP     = 4'd4;
    localparam logic [3:0] K_LUI    = 4'd5;
    localparam logic [3:0] K_BRANCH = 4'd6;
    localparam logic [3:0] K_JALR   = 4'd7;
    localparam logic [3:0] K_JAL    = 4'd8;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // ------------------------------------------------------------------
    // Combinational encoder
    // ------------------------------------------------------------------
    logic [31:0] enc_instr;
    logic        enc_illegal;
    logic        enc_err;

    always_comb begin
        enc_instr   = '0;
        enc_illegal = 1'b0;
        unique case (req_kind)
            K_LOAD:   enc_instr = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_LOAD};
            K_OPIMM: begin
                enc_instr = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_OPIMM};
                // Shift-immediates carry funct7 in the top bits instead of imm[11:5].
                if (req_funct3 == 3'b001 || req_funct3 == 3'b101)
                    enc_instr[31:25] = {1'b0, req_funct7b5, 5'b00000};
            end
            K_AUIPC:  enc_instr = {req_imm[31:12], req_rd, OPC_AUIPC};
            K_STORE:  enc_instr = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OPC_STORE};
            K_OP:     enc_instr = {1'b0, req_funct7b5, 5'b00000, req_rs2, req_rs1, req_funct3, req_rd, OPC_OP};
            K_LUI:    enc_instr = {req_imm[31:12], req_rd, OPC_LUI};
            K_BRANCH: enc_instr = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                                   req_imm[4:1], req_imm[11], OPC_BRANCH};
            K_JALR:   enc_instr = {req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_JALR};
            K_JAL:    enc_instr = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OPC_JAL};
            default:  enc_illegal = 1'b1;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // An immediate fits an N-bit signed field when every bit above the field equals the sign bit.
    logic fit_i, fit_b, fit_j, u_low_zero, range_err;

    assign fit_i      = (&req_imm[31:11]) | ~(|req_imm[31:11]);
    assign fit_b      = ((&req_imm[31:12]) | ~(|req_imm[31:12])) & ~req_imm[0];
    assign fit_j      = ((&req_imm[31:20]) | ~(|req_imm[31:20])) & ~req_imm[0];
    assign u_low_zero = ~(|req_imm[11:0]);

    always_comb begin
        range_err = 1'b0;
        unique case (req_kind)
            K_LOAD, K_OPIMM, K_JALR, K_STORE: range_err = ~fit_i;
            K_BRANCH:                         range_err = ~fit_b;
            K_JAL:                            range_err = ~fit_j;
            K_AUIPC, K_LUI:                   range_err = ~u_low_zero;
            default:                          range_err = 1'b0;
        endcase
    end

    assign enc_err = enc_illegal | range_err;
`else
    assign enc_err = enc_illegal;
`endif

    // ------------------------------------------------------------------
    // Output queue
    // ------------------------------------------------------------------
    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q, count_nxt;
    logic          valid_q;
    logic          push, pop;

    // Full check uses the registered count only, so a same-cycle pop never opens a slot.
    assign req_ready = (count_q < FULL) & ~flush;
    assign push      = req_valid & req_ready;
    assign pop       = valid_q & out_ready;

    always_comb begin
        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_nxt;
            valid_q <= (count_nxt != '0);
        end
    end

    // Storage is zeroed only by reset; flush leaves old words in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= {enc_err, enc_instr};
        end
    end

    assign out_valid = valid_q;
    assign out_err   = mem[rd_ptr][32];
    assign out_instr = mem[rd_ptr][31:0];
    assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Purpose : directed-vector bench for instr_encoder with a field-level encoding model and a queue scoreboard.
// Latency : model head updates on the same edge the DUT accepts a request.
// Backpres: model queue follows the same push/pop acceptance rules; outputs compared every falling edge.
module tb_instr_encoder;

    localparam int DEPTH = 4;

`ifdef ENC_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_kind;
    logic [2:0]  req_funct3;
    logic        req_funct7b5;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    logic [32:0] q[$];

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoding model: plain shift/mask arithmetic on the instruction-set field layout.
    function automatic logic [32:0] model_enc(input int unsigned kind, input int unsigned f3,
                                              input int unsigned b5, input int unsigned rd,
                                              input int unsigned rs1, input int unsigned rs2,
                                              input logic [31:0] imm);
        int unsigned opc [9] = '{3, 19, 23, 35, 51, 55, 99, 103, 111};
        int unsigned u, w;
        int          s;
        bit          ill, rc;
        u = imm; s = $signed(imm); w = 0; ill = 0; rc = 0;
        case (kind)
            0, 1, 7: begin
                w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (((kind == 7) ? 0 : f3) << 12) | (rd << 7) | opc[kind];
                if (kind == 1 && (f3 == 1 || f3 == 5)) w = (w & 32'h01FF_FFFF) | (b5 << 30);
                rc = (s < -2048) || (s > 2047);
            end
            2, 5: begin
                w = (u & 32'hFFFF_F000) | (rd << 7) | opc[kind];
                rc = (u % 4096) != 0;
            end
            3: begin
                w = (((u >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((u & 31) << 7) | opc[3];
                rc = (s < -2048) || (s > 2047);
            end
            4: w = (b5 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc[4];
            6: begin
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15) |
                    (f3 << 12) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | opc[6];
                rc = (s < -4096) || (s > 4094) || (u % 2 != 0);
            end
            8: begin
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20) |
                    (((u >> 12) & 255) << 12) | (rd << 7) | opc[8];
                rc = (s < -1048576) || (s > 1048574) || (u % 2 != 0);
            end
            default: begin w = 0; ill = 1; end
        endcase
        return {ill | (RC & rc), w};
    endfunction

    // Queue model.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            bit do_pop, do_push;
            do_pop  = (q.size() > 0) && out_ready;
            do_push = req_valid && (q.size() < DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_push)
                q.push_back(model_enc(int'(req_kind), int'(req_funct3), int'(req_funct7b5),
                                      int'(req_rd), int'(req_rs1), int'(req_rs2), req_imm));
        end
    end

    // Compare process.
    always @(negedge clk) begin
        chk("count", 32'(count), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("req_ready", 32'(req_ready), 32'((q.size() < DEPTH) && !flush));
        if (q.size() != 0) begin
            chk("head_instr", out_instr, q[0][31:0]);
            chk("head_err", 32'(out_err), 32'(q[0][32]));
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive_req(input logic [3:0] k, input logic [2:0] f3, input logic b5,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] imm);
        bit acc;
        acc = 0;
        req_kind = k; req_funct3 = f3; req_funct7b5 = b5;
        req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk); #1;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout: request kind %0d never accepted", k);
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d entries left", q.size());
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic single(input string name, input logic [3:0] k, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm, input logic [31:0] exp_w, input logic exp_e);
        logic [32:0] m;
        m = model_enc(int'(k), int'(f3), 0, int'(rd), int'(rs1), int'(rs2), imm);
        chk({name, "_model"}, m[31:0], exp_w);
        drive_req(k, f3, 1'b0, rd, rs1, rs2, imm);
        @(negedge clk);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_instr"}, out_instr, exp_w);
        chk({name, "_err"}, 32'(out_err), 32'(exp_e));
        @(posedge clk); #1;
        drain();
    endtask

    typedef struct {
        logic [3:0]  k;
        logic [2:0]  f3;
        logic        b5;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs [12] = '{
        '{4'd0,  3'd2, 1'b1, 5'd5,  5'd6,  5'd31, 32'hFFFF_FFF8},
        '{4'd1,  3'd5, 1'b1, 5'd7,  5'd8,  5'd0,  32'h0000_0FE3},
        '{4'd1,  3'd1, 1'b0, 5'd9,  5'd10, 5'd0,  32'h0000_041F},
        '{4'd2,  3'd3, 1'b1, 5'd11, 5'd12, 5'd13, 32'hFFFF_F123},
        '{4'd3,  3'd0, 1'b1, 5'd0,  5'd14, 5'd15, 32'hFFFF_F801},
        '{4'd4,  3'd0, 1'b1, 5'd16, 5'd17, 5'd18, 32'h0000_0000},
        '{4'd4,  3'd7, 1'b0, 5'd19, 5'd20, 5'd21, 32'h0000_1234},
        '{4'd5,  3'd7, 1'b1, 5'd22, 5'd31, 5'd31, 32'hABCD_E123},
        '{4'd6,  3'd5, 1'b1, 5'd0,  5'd23, 5'd24, 32'h0000_0FFE},
        '{4'd7,  3'd3, 1'b1, 5'd25, 5'd26, 5'd27, 32'hFFFF_F800},
        '{4'd8,  3'd0, 1'b0, 5'd28, 5'd0,  5'd0,  32'hFFF0_0000},
        '{4'd15, 3'd7, 1'b1, 5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF}
    };

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
        req_kind = '0; req_funct3 = '0; req_funct7b5 = 1'b0;
        req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;

        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Hand-computed words.
        single("addi",  4'd1,  3'd0, 5'd1, 5'd0, 5'd0, 32'd5,          32'h0050_0093, 1'b0);
        single("sw",    4'd3,  3'd2, 5'd0, 5'd3, 5'd2, 32'd8,          32'h0021_A423, 1'b0);
        single("beq",   4'd6,  3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC,  32'hFE20_8EE3, 1'b0);
        single("jal",   4'd8,  3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800,  32'h0010_00EF, 1'b0);
        single("lui",   4'd5,  3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000,  32'h1234_52B7, 1'b0);
        single("illeg", 4'd12, 3'd0, 5'd1, 5'd2, 5'd3, 32'h0000_0010,  32'h0000_0000, 1'b1);
        single("addi4k",4'd1,  3'd0, 5'd1, 5'd0, 5'd0, 32'd4096,       32'h0000_0093, RC);

        // Mixed patterns at full throughput, checked by the model.
        out_ready = 1'b1;
        foreach (vecs[i])
            drive_req(vecs[i].k, vecs[i].f3, vecs[i].b5, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
        drain();

        // Backpressure: fill, hold a fifth request, then release the consumer.
        for (int i = 0; i < 4; i++)
            drive_req(4'd1, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i * 3));
        @(negedge clk);
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        req_kind = 4'd4; req_funct3 = 3'd0; req_funct7b5 = 1'b1;
        req_rd = 5'd9; req_rs1 = 5'd10; req_rs2 = 5'd11; req_imm = '0;
        req_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_pop_count", 32'(count), 32'd3);
        chk("after_pop_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("push_pop_count", 32'(count), 32'd3);
        @(posedge clk); #1;
        drain();

        // Flush with a concurrent push.
        for (int i = 0; i < 3; i++)
            drive_req(4'd0, 3'd2, 1'b0, 5'(i + 4), 5'd2, 5'd0, 32'(i * 4));
        flush = 1'b1;
        req_kind = 4'd5; req_rd = 5'd3; req_imm = 32'h0000_1000; req_valid = 1'b1;
        @(negedge clk);
        chk("flush_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of a drain.
        for (int i = 0; i < 3; i++)
            drive_req(4'd4, 3'd6, 1'b0, 5'(i + 1), 5'd7, 5'd8, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_instr", out_instr, 32'd0);
        chk("mid_rst_err", 32'(out_err), 32'd0);
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        single("post_rst", 4'd7, 3'd5, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'hFFF1_00E7, 1'b0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
